// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the request, handshake and grant signals shared between the read
// arbiter and the masters/slave around it.
interface axi_rd_arbiter_if;
    logic [3:0] s_arvalid;
    logic       m_arready;
    logic       m_rvalid;
    logic       m_rready;
    logic       m_rlast;
    logic [3:0] grnt;
    logic [1:0] grnt_id;
    logic       busy;
    logic       timeout_err;

    // arbiter side
    modport slave (
        input  s_arvalid, m_arready, m_rvalid, m_rready, m_rlast,
        output grnt, grnt_id, busy, timeout_err
    );

    // requester / environment side
    modport master (
        output s_arvalid, m_arready, m_rvalid, m_rready, m_rlast,
        input  grnt, grnt_id, busy, timeout_err
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter for one shared AXI read port (AR + R) among 4 masters.
// Grant is held from arbitration until RLAST; a watchdog frees stalled grants.
module axi_rd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           ACLK,
    input  logic           ARESET,
    axi_rd_arbiter_if.slave bus
);

    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WDW-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [3:0]     grnt_q, grnt_n;
    logic [1:0]     id_q, id_n;
    logic           busy_q, busy_n;
    logic           terr_q, terr_n;
    logic [1:0]     ptr, ptr_n;
    logic [WDW-1:0] wdog, wdog_n;

    logic           pick_vld;
    logic [1:0]     pick_id;
    logic [1:0]     cand;
    logic           ar_hs, r_beat, progress, wd_expire;

    // first requester at or after ptr, wrapping modulo 4
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = ptr;
        cand     = '0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!pick_vld && bus.s_arvalid[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign ar_hs     = (state == ADDR) && bus.s_arvalid[id_q] && bus.m_arready;
    assign r_beat    = (state == DATA) && bus.m_rvalid && bus.m_rready;
    assign progress  = ar_hs || r_beat;
    assign wd_expire = (TIMEOUT_CYCLES > 0) && !progress && (wdog == WD_LAST);

    always_comb begin
        state_n = state;
        grnt_n  = grnt_q;
        id_n    = id_q;
        busy_n  = busy_q;
        terr_n  = 1'b0;
        ptr_n   = ptr;
        wdog_n  = wdog;
        case (state)
            IDLE: begin
                wdog_n = '0;
                if (pick_vld) begin
                    state_n = ADDR;
                    grnt_n  = 4'b0001 << pick_id;
                    id_n    = pick_id;
                    busy_n  = 1'b1;
                end
            end
            ADDR, DATA: begin
                if (r_beat && bus.m_rlast) begin
                    state_n = IDLE;
                    grnt_n  = '0;
                    id_n    = '0;
                    busy_n  = 1'b0;
                    ptr_n   = id_q + 2'd1;
                    wdog_n  = '0;
                end else if (progress) begin
                    wdog_n = '0;
                    if (ar_hs) state_n = DATA;
                end else if (wd_expire) begin
                    // stalled owner loses the grant; it ranks last next round
                    state_n = IDLE;
                    grnt_n  = '0;
                    id_n    = '0;
                    busy_n  = 1'b0;
                    ptr_n   = id_q + 2'd1;
                    wdog_n  = '0;
                    terr_n  = 1'b1;
                end else if ((TIMEOUT_CYCLES > 0) && (wdog != WD_MAX)) begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grnt_n  = '0;
                id_n    = '0;
                busy_n  = 1'b0;
                wdog_n  = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= IDLE;
            grnt_q <= '0;
            id_q   <= '0;
            busy_q <= 1'b0;
            terr_q <= 1'b0;
            ptr    <= '0;
            wdog   <= '0;
        end else begin
            state  <= state_n;
            grnt_q <= grnt_n;
            id_q   <= id_n;
            busy_q <= busy_n;
            terr_q <= terr_n;
            ptr    <= ptr_n;
            wdog   <= wdog_n;
        end
    end

    assign bus.grnt        = grnt_q;
    assign bus.grnt_id     = id_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

    a_grant_shape: assert property (@(posedge ACLK) disable iff (ARESET)
        $onehot0(grnt_q) && (busy_q == (grnt_q != 4'b0000)));

endmodule
